// File: rtl/frac_div_pkg.sv
// Shared definitions for the fractional clock divider and its downstream
// pulse-train checker.
//   state_t         : checker alignment states
//   *_DEF constants : default dual-modulus pattern (SHORT_REPS_DEF intervals
//                     of SHORT_DIV_DEF cycles, then one of LONG_DIV_DEF)
package frac_div_pkg;

    typedef enum logic [1:0] {
        IDLE, // checker disabled
        HUNT, // waiting for the first pulse, no interval reference yet
        ACQ,  // looking for the long interval to find frame alignment
        LOCK  // aligned, every interval is checked
    } state_t;

    localparam int SHORT_DIV_DEF  = 5;
    localparam int SHORT_REPS_DEF = 9;
    localparam int LONG_DIV_DEF   = 8;

endpackage

// File: rtl/pulse_interval_meter.sv
// Measures the distance in clk_in cycles between successive pulses.
//   clk_in, rst : clock, asynchronous active-high reset
//   enable      : meter runs while high, held at zero while low
//   pulse_in    : one-cycle-high pulse train
//   measured    : ivl+1, saturating; the interval ending at this cycle if a
//                 pulse is present, otherwise the elapsed length so far
//   strobe      : pulse_in qualified by enable
module pulse_interval_meter #(
    parameter int IVL_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [IVL_W-1:0] measured,
    output logic             strobe
);

    localparam logic [IVL_W-1:0] IVL_MAX = '1;

    logic [IVL_W-1:0] ivl;

    assign strobe   = enable & pulse_in;
    assign measured = (ivl == IVL_MAX) ? IVL_MAX : ivl + IVL_W'(1);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ivl <= '0;
        end else if (!enable || pulse_in) begin
            ivl <= '0;
        end else begin
            ivl <= measured; // measured is already the saturated increment
        end
    end

endmodule

// File: rtl/frac_pulse_checker.sv
// Monitors the fractional divider's pulse train for the dual-modulus pattern
// (SHORT_REPS intervals of SHORT_DIV cycles, then one of LONG_DIV cycles).
//   clk_in, rst : clock, asynchronous active-high reset
//   enable      : checker active; low forces IDLE and clears alignment
//   err_clr     : synchronous clear of err_cnt (wins over an increment)
//   pulse_in    : divider output pulses
//   locked      : frame alignment held
//   err         : one-cycle pulse per early or missing pulse while locked
//   frame_done  : one-cycle pulse per correctly checked long interval
//   period_last : last measured interval (updated in ACQ and LOCK)
//   err_cnt     : saturating violation count
module frac_pulse_checker
    import frac_div_pkg::*;
#(
    parameter int SHORT_DIV  = SHORT_DIV_DEF,
    parameter int SHORT_REPS = SHORT_REPS_DEF,
    parameter int LONG_DIV   = LONG_DIV_DEF,
    parameter int IVL_W      = 8,
    parameter int ERR_W      = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             err_clr,
    input  logic             pulse_in,
    output logic             locked,
    output logic             err,
    output logic             frame_done,
    output logic [IVL_W-1:0] period_last,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int SIDX_W = $clog2(SHORT_REPS + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t            state, next_state;
    logic [SIDX_W-1:0] short_idx, short_idx_next;
    logic [IVL_W-1:0]  measured, expected;
    logic              strobe, long_slot, viol, frame_hit, capture;

    pulse_interval_meter #(.IVL_W(IVL_W)) u_meter (
        .clk_in   (clk_in),
        .rst      (rst),
        .enable   (enable),
        .pulse_in (pulse_in),
        .measured (measured),
        .strobe   (strobe)
    );

    // short_idx == SHORT_REPS marks the slot where the long interval is due.
    assign long_slot = (short_idx >= SIDX_W'(SHORT_REPS));
    assign expected  = long_slot ? IVL_W'(LONG_DIV) : IVL_W'(SHORT_DIV);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state     = state;
        short_idx_next = short_idx;
        viol           = 1'b0;
        frame_hit      = 1'b0;
        capture        = 1'b0;
        if (!enable) begin
            next_state     = IDLE;
            short_idx_next = '0;
        end else begin
            unique case (state)
                IDLE: next_state = HUNT;
                HUNT: if (strobe) next_state = ACQ;
                ACQ: begin
                    if (strobe) begin
                        capture = 1'b1;
                        if (measured == IVL_W'(LONG_DIV)) begin
                            next_state     = LOCK;
                            short_idx_next = '0;
                        end
                    end
                end
                LOCK: begin
                    if (strobe) begin
                        capture = 1'b1;
                        if (measured == expected) begin
                            if (long_slot) begin
                                short_idx_next = '0;
                                frame_hit      = 1'b1;
                            end else begin
                                short_idx_next = short_idx + SIDX_W'(1);
                            end
                        end else begin
                            viol       = 1'b1; // early pulse
                            next_state = ACQ;
                        end
                    end else if (measured == expected) begin
                        viol       = 1'b1; // expected pulse did not arrive
                        next_state = ACQ;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            short_idx <= '0;
        end else begin
            state     <= next_state;
            short_idx <= short_idx_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            locked      <= 1'b0;
            err         <= 1'b0;
            frame_done  <= 1'b0;
            period_last <= '0;
            err_cnt     <= '0;
        end else begin
            locked     <= (next_state == LOCK);
            err        <= viol;
            frame_done <= frame_hit;
            if (capture) begin
                period_last <= measured;
            end
            if (err_clr) begin
                err_cnt <= '0;
            end else if (viol && err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frac_pulse_checker.sv
// Self-checking bench for frac_pulse_checker. A reference divider produces the
// nominal pulse train; a timestamp-based model predicts every output.
module tb_frac_pulse_checker;

    localparam int SHORT_DIV  = 5;
    localparam int SHORT_REPS = 9;
    localparam int LONG_DIV   = 8;
    localparam int IVL_W      = 8;
    localparam int ERR_W      = 8;
    localparam int IVL_SAT    = (1 << IVL_W) - 1;
    localparam int ERR_SAT    = (1 << ERR_W) - 1;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             enable;
    logic             err_clr;
    logic             pulse_in;
    logic             locked;
    logic             err;
    logic             frame_done;
    logic [IVL_W-1:0] period_last;
    logic [ERR_W-1:0] err_cnt;

    always #5 clk_in = ~clk_in;

    frac_pulse_checker #(
        .SHORT_DIV  (SHORT_DIV),
        .SHORT_REPS (SHORT_REPS),
        .LONG_DIV   (LONG_DIV),
        .IVL_W      (IVL_W),
        .ERR_W      (ERR_W)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .enable      (enable),
        .err_clr     (err_clr),
        .pulse_in    (pulse_in),
        .locked      (locked),
        .err         (err),
        .frame_done  (frame_done),
        .period_last (period_last),
        .err_cnt     (err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pattern position plus the timestamp of the last pulse.
    int m_now, m_last, m_pos;
    bit m_active, m_synced, m_locked;
    bit e_locked, e_err, e_frame;
    int e_period, e_cnt;

    // Reference divider: counts cycles into the current pattern slot.
    int d_cnt, d_idx;

    task automatic div_reset();
        d_cnt = 0;
        d_idx = 0;
    endtask

    task automatic div_tick(output bit p);
        int want;
        want  = (d_idx < SHORT_REPS) ? SHORT_DIV : LONG_DIV;
        d_cnt = d_cnt + 1;
        p     = 1'b0;
        if (d_cnt == want) begin
            p     = 1'b1;
            d_cnt = 0;
            d_idx = (d_idx == SHORT_REPS) ? 0 : d_idx + 1;
        end
    endtask

    task automatic model_reset();
        m_now = 0; m_last = 0; m_pos = 0;
        m_active = 0; m_synced = 0; m_locked = 0;
        e_locked = 0; e_err = 0; e_frame = 0; e_period = 0; e_cnt = 0;
    endtask

    task automatic model_step(input bit p, input bit en, input bit clr);
        int  gap, want;
        bit  viol;
        m_now   = m_now + 1;
        viol    = 1'b0;
        e_frame = 1'b0;
        if (!en) begin
            m_active = 0; m_synced = 0; m_locked = 0; m_pos = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (!m_synced) begin
            if (p) begin
                m_synced = 1;
                m_last   = m_now;
            end
        end else begin
            gap  = m_now - m_last;
            if (gap > IVL_SAT) gap = IVL_SAT;
            want = (m_pos < SHORT_REPS) ? SHORT_DIV : LONG_DIV;
            if (p) begin
                e_period = gap;
                m_last   = m_now;
                if (!m_locked) begin
                    if (gap == LONG_DIV) begin
                        m_locked = 1;
                        m_pos    = 0;
                    end
                end else if (gap == want) begin
                    if (m_pos == SHORT_REPS) begin
                        m_pos   = 0;
                        e_frame = 1'b1;
                    end else begin
                        m_pos = m_pos + 1;
                    end
                end else begin
                    viol     = 1'b1;
                    m_locked = 0;
                end
            end else if (m_locked && gap == want) begin
                viol     = 1'b1;
                m_locked = 0;
            end
        end
        e_err    = viol;
        e_locked = m_locked;
        if (clr) e_cnt = 0;
        else if (viol && e_cnt < ERR_SAT) e_cnt = e_cnt + 1;
    endtask

    // One clock: drive inputs at the falling edge, let the model follow the
    // rising edge, then return 1 time unit after it for sampling.
    task automatic step(input bit p, input bit en, input bit clr);
        @(negedge clk_in);
        pulse_in = p;
        enable   = en;
        err_clr  = clr;
        @(posedge clk_in);
        model_step(p, en, clr);
        #1;
    endtask

    // Hold reset across an edge and release it just after a rising edge so the
    // next step() call is edge 1 for both model and divider.
    task automatic apply_reset();
        rst = 1'b1; enable = 1'b1; err_clr = 1'b0; pulse_in = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        rst = 1'b0;
        model_reset();
        div_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; err_clr = 1'b0; pulse_in = 1'b0;
        #1;
        n_checks++;
        if ({locked, err, frame_done, period_last, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %b/%b/%b/%0d/%0d, want all 0",
                     locked, err, frame_done, period_last, err_cnt);
        end
        enable = 1'b1; pulse_in = 1'b1;
        @(posedge clk_in);
        #1;
        n_checks++;
        if ({locked, err, frame_done, period_last, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %b/%b/%b/%0d/%0d, want all 0",
                     locked, err, frame_done, period_last, err_cnt);
        end
    endtask

    task automatic test_reference_train();
        bit p;
        int first_fd = 0, last_fd = 0;
        apply_reset();
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            n_checks++;
            if ({locked, err, frame_done} !== {e_locked, e_err, e_frame} ||
                period_last !== e_period[IVL_W-1:0] || err_cnt !== e_cnt[ERR_W-1:0]) begin
                n_fail++;
                $display("FAIL train cyc %0d: got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc,
                         locked, err, frame_done, period_last, err_cnt,
                         e_locked, e_err, e_frame, e_period, e_cnt);
            end
            if (cyc == 52 || cyc == 53) begin
                n_checks++;
                if (locked !== (cyc == 53)) begin
                    n_fail++;
                    $display("FAIL lock_edge cyc %0d: locked=%b want %b", cyc, locked, cyc == 53);
                end
            end
            if (frame_done === 1'b1) begin
                if (first_fd == 0) first_fd = cyc;
                else begin
                    n_checks++;
                    if (cyc - last_fd != 53) begin
                        n_fail++;
                        $display("FAIL frame_spacing cyc %0d: got %0d want 53", cyc, cyc - last_fd);
                    end
                end
                last_fd = cyc;
            end
        end
        n_checks++;
        if (first_fd != 106) begin
            n_fail++;
            $display("FAIL first_frame_done: got edge %0d want 106", first_fd);
        end
    endtask

    task automatic test_extra_pulse();
        bit p;
        bit found = 0;
        int relock_at = 0;
        div_tick(p);
        step(p, 1'b1, 1'b1);
        for (int k = 0; k < 120 && !found; k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            if (e_frame) found = 1;
        end
        n_checks++;
        if (!found || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL extra_setup: frame_done=%b, want 1 within 120 cycles", frame_done);
        end
        div_tick(p);
        step(p, 1'b1, 1'b0);
        div_tick(p);
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (err !== 1'b1 || err_cnt !== ERR_W'(1) || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL extra_pulse: err/cnt/locked=%b/%0d/%b want 1/1/0", err, err_cnt, locked);
        end
        for (int k = 1; k <= 120 && relock_at == 0; k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            n_checks++;
            if ({locked, err, frame_done} !== {e_locked, e_err, e_frame} ||
                period_last !== e_period[IVL_W-1:0] || err_cnt !== e_cnt[ERR_W-1:0]) begin
                n_fail++;
                $display("FAIL extra_relock k %0d: got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", k,
                         locked, err, frame_done, period_last, err_cnt,
                         e_locked, e_err, e_frame, e_period, e_cnt);
            end
            if (locked === 1'b1) relock_at = k;
        end
        n_checks++;
        if (relock_at != 51) begin
            n_fail++;
            $display("FAIL extra_relock_time: relocked %0d cycles after fault, want 51", relock_at);
        end
    endtask

    task automatic test_missing_pulse();
        bit p;
        bit found = 0;
        div_tick(p);
        step(p, 1'b1, 1'b1);
        for (int k = 0; k < 200 && !found; k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            if (e_frame) found = 1;
        end
        n_checks++;
        if (!found || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL missing_setup: locked=%b, want 1 with a frame_done", locked);
        end
        for (int k = 1; k <= SHORT_DIV; k++) begin
            div_tick(p);
            step(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (err !== (k == SHORT_DIV) || locked !== (k != SHORT_DIV)) begin
                n_fail++;
                $display("FAIL missing_pulse k %0d: err/locked=%b/%b want %b/%b", k,
                         err, locked, k == SHORT_DIV, k != SHORT_DIV);
            end
        end
        n_checks++;
        if (err_cnt !== ERR_W'(1)) begin
            n_fail++;
            $display("FAIL missing_cnt: err_cnt=%0d want 1", err_cnt);
        end
        for (int k = 0; k < 150; k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            n_checks++;
            if ({locked, err, frame_done} !== {e_locked, e_err, e_frame} ||
                period_last !== e_period[IVL_W-1:0] || err_cnt !== e_cnt[ERR_W-1:0]) begin
                n_fail++;
                $display("FAIL missing_after k %0d: got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", k,
                         locked, err, frame_done, period_last, err_cnt,
                         e_locked, e_err, e_frame, e_period, e_cnt);
            end
        end
    endtask

    // Repeated lock (8-cycle gap) followed by a pulse one cycle later.
    task automatic test_saturation();
        for (int it = 0; it < 300; it++) begin
            for (int k = 0; k < 9; k++) begin
                step(k >= 7, 1'b1, 1'b0);
                n_checks++;
                if ({locked, err, frame_done} !== {e_locked, e_err, e_frame} ||
                    period_last !== e_period[IVL_W-1:0] || err_cnt !== e_cnt[ERR_W-1:0]) begin
                    n_fail++;
                    $display("FAIL sat it %0d k %0d: got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                             it, k, locked, err, frame_done, period_last, err_cnt,
                             e_locked, e_err, e_frame, e_period, e_cnt);
                end
            end
        end
        n_checks++;
        if (err_cnt !== ERR_W'(ERR_SAT)) begin
            n_fail++;
            $display("FAIL sat_value: err_cnt=%0d want %0d", err_cnt, ERR_SAT);
        end
        for (int k = 0; k < 8; k++) step(k == 7, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (err !== 1'b1 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL clr_priority: err/err_cnt=%b/%0d want 1/0", err, err_cnt);
        end
    endtask

    task automatic test_enable_drop();
        bit p;
        bit seen = 0;
        logic [ERR_W-1:0] held;
        for (int k = 0; k < 200 && !seen; k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            if (e_locked) seen = 1;
        end
        for (int k = 0; k < 20; k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_setup: locked=%b want 1", locked);
        end
        held = err_cnt;
        for (int k = 0; k < 10; k++) begin
            div_tick(p);
            step(p, 1'b0, 1'b0);
            n_checks++;
            if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== held) begin
                n_fail++;
                $display("FAIL enable_low k %0d: locked/err/cnt=%b/%b/%0d want 0/0/%0d",
                         k, locked, err, err_cnt, held);
            end
        end
        seen = 0;
        for (int k = 0; k < 150; k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            n_checks++;
            if ({locked, err, frame_done} !== {e_locked, e_err, e_frame} ||
                period_last !== e_period[IVL_W-1:0] || err_cnt !== e_cnt[ERR_W-1:0]) begin
                n_fail++;
                $display("FAIL reenable k %0d: got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", k,
                         locked, err, frame_done, period_last, err_cnt,
                         e_locked, e_err, e_frame, e_period, e_cnt);
            end
            if (locked === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reenable_lock: locked=%b never rose within 150 cycles", locked);
        end
    endtask

    task automatic test_random();
        bit p, en, clr;
        int off = 0;
        for (int k = 0; k < 3000; k++) begin
            div_tick(p);
            if ($urandom_range(0, 39) == 0) p = ~p;
            if (off == 0 && $urandom_range(0, 299) == 0) off = $urandom_range(1, 12);
            en  = (off == 0);
            if (off > 0) off--;
            clr = ($urandom_range(0, 199) == 0);
            step(p, en, clr);
            n_checks++;
            if ({locked, err, frame_done} !== {e_locked, e_err, e_frame} ||
                period_last !== e_period[IVL_W-1:0] || err_cnt !== e_cnt[ERR_W-1:0]) begin
                n_fail++;
                $display("FAIL random k %0d: got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", k,
                         locked, err, frame_done, period_last, err_cnt,
                         e_locked, e_err, e_frame, e_period, e_cnt);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit p;
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            if (e_locked) seen = 1;
        end
        for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: locked=%b want 1", locked);
        end
        @(negedge clk_in);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({locked, err, frame_done, period_last, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rst_midframe: got %b/%b/%b/%0d/%0d want all 0",
                     locked, err, frame_done, period_last, err_cnt);
        end
        apply_reset();
        n_checks++;
        if (err !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: err/locked=%b/%b want 0/0", err, locked);
        end
        for (int cyc = 1; cyc <= 120; cyc++) begin
            div_tick(p);
            step(p, 1'b1, 1'b0);
            n_checks++;
            if ({locked, err, frame_done} !== {e_locked, e_err, e_frame} ||
                period_last !== e_period[IVL_W-1:0] || err_cnt !== e_cnt[ERR_W-1:0]) begin
                n_fail++;
                $display("FAIL rst_relock cyc %0d: got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", cyc,
                         locked, err, frame_done, period_last, err_cnt,
                         e_locked, e_err, e_frame, e_period, e_cnt);
            end
            if (cyc == 53) begin
                n_checks++;
                if (locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_lock_edge: locked=%b at edge 53 want 1", locked);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reference_train();
        test_extra_pulse();
        test_missing_pulse();
        test_saturation();
        test_enable_drop();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frac_pulse_checker.md
# frac_pulse_checker

Downstream monitor for the fractional clock divider's single-cycle output pulse train. It checks that the train follows the dual-modulus pattern: SHORT_REPS intervals of SHORT_DIV cycles, then one interval of LONG_DIV cycles, repeating. With defaults that is 9×5 + 1×8 = 53 cycles per 10 pulses. It acquires frame alignment, reports lock, flags every period violation, and counts errors for the bring-up and self-test logic.

## Interface
- SHORT_DIV, 5, expected short interval in clk_in cycles (≥2)
- SHORT_REPS, 9, short intervals per frame (≥1)
- LONG_DIV, 8, expected long interval (≥2, ≠ SHORT_DIV)
- IVL_W, 8, interval measurement width
- ERR_W, 8, error counter width
- clk_in  input  1  sole clock; pulse_in is synchronous to it
- rst  input  1  asynchronous, active-high reset
- enable  input  1  checker active; low forces IDLE
- err_clr  input  1  synchronous clear of err_cnt
- pulse_in  input  1  divider output, one-cycle-high pulses
- locked  output  1  frame alignment held
- err  output  1  one-cycle pulse per detected violation
- frame_done  output  1  one-cycle pulse on each correctly checked long interval while locked
- period_last  output  IVL_W  last measured interval
- err_cnt  output  ERR_W  saturating violation count

## Operation
- Interval meter ivl (IVL_W bits) runs while enable=1.
  - Pulse cycle: measured = ivl+1, then ivl←0.
  - Otherwise ivl←ivl+1, saturating at all-ones; measured also saturates.
- States:
  - IDLE: enable=0.
  - HUNT: waiting for the first pulse; no valid interval yet.
  - ACQ: searching for the long interval.
  - LOCK: checking.
- Transitions:
  - IDLE→HUNT when enable=1.
  - HUNT→ACQ on first pulse.
  - ACQ: pulse with measured==LONG_DIV → LOCK with short_idx←0. Any other measured value stays in ACQ with no error.
  - LOCK: expected = SHORT_DIV if short_idx<SHORT_REPS, else LONG_DIV.
    - Pulse with measured==expected: advance short_idx. On the long interval, short_idx←0 and frame_done fires.
    - Pulse with measured≠expected (early pulse): violation.
    - No pulse while ivl+1==expected (missing pulse): violation.
  - Any state, enable=0 → IDLE next cycle: ivl, short_idx and locked clear; err_cnt holds.
- Violation handling: err pulses, err_cnt increments (saturating), state→ACQ, locked←0. In ACQ, ivl continues from its current value; an early pulse sets ivl←0.
- period_last updates on every pulse outside IDLE/HUNT. It holds in IDLE/HUNT.
- err_cnt rule: err_clr has priority over an increment in the same cycle, giving err_cnt=0.
- pulse_in high on consecutive cycles: each high cycle is a pulse (measured=1, a violation when locked).

## Timing
- All outputs registered. Reset values: locked=0, err=0, frame_done=0, period_last=0, err_cnt=0; internal state IDLE, ivl=0, short_idx=0.
- Latency: err, frame_done and locked change in the cycle after the clk_in edge that samples the deciding pulse_in value (or the missing pulse).
- Reset asserted mid-frame: all state and outputs return to reset values immediately (asynchronous). After reset releases, the block re-hunts from scratch.
- Reference alignment: with the divider and checker reset together and enable=1 from release, divider pulses fall on edges 5,10,…,45,53,58,….
  - locked rises after edge 53.
  - First frame_done follows edge 106.

## Structure
- Shared package frac_div_pkg holds:
  - state enum {IDLE, HUNT, ACQ, LOCK};
  - default constants SHORT_DIV=5, SHORT_REPS=9, LONG_DIV=8. The divider uses the same constants.
- Sub-module pulse_interval_meter: the ivl counter, the measured output, saturation, and a pulse-strobe output. Top level holds the FSM, short_idx, and error/frame logic.

## Test plan
- Paired with the reference divider, 1000 cycles, enable=1 → locked after edge 53, frame_done every 53 cycles, err never asserts, period_last alternates 5 (×9) / 8.
- Force one extra pulse 2 cycles after a pulse while locked → err one cycle later, err_cnt=1, locked=0, relock on the next 8-cycle interval.
- Suppress one short pulse while locked → err after the edge where the 5th cycle passed without a pulse, err_cnt=1, back in ACQ.
- Inject 300 violations with ERR_W=8 → err_cnt saturates at 255. err_clr coincident with a violation → err_cnt=0.
- Deassert enable mid-frame for 10 cycles → locked=0 next cycle, err_cnt held, full reacquisition after re-enable.
- Assert rst at an arbitrary cycle while locked → all outputs 0 immediately, no err pulse, normal lock after release.
